// File: rtl/fifo_pkg.sv
// Shared sizing for the line FIFO: default word/address widths and the level-width rule.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;

  // level must represent 0..DEPTH inclusive, hence one bit more than the pointers
  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/ram_pdp_param.sv
// Single-clock pseudo-dual-port RAM: one write port, one read port with a registered,
// hold-on-no-read output. The storage array itself is never reset.
module ram_pdp_param #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Only the output register resets; it doubles as the FIFO's rd_data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_fifo_pdp.sv
// First-word-fall-through line FIFO built on a registered-output PDP RAM.
// The RAM output register is rd_data; level counts RAM words plus the presented word.
module line_fifo_pdp
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  output logic                                rd_valid,
  input  logic                                rd_ready,
  output logic [DATA_WIDTH-1:0]               rd_data,
  output logic [level_width(ADDR_WIDTH)-1:0]  level,
  output logic                                almost_full,
  output logic                                empty,
  output logic                                ovf_err,
  output logic                                udf_err
);

  localparam int            LW      = level_width(ADDR_WIDTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(1 << ADDR_WIDTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic          full;
  logic          wr_acc;
  logic          consume;
  logic          ram_re;
  logic [LW-1:0] ram_cnt;

  // Handshakes: a word transfers on a rising edge only when the side's valid and
  // ready are both high; valid never waits on ready, and rd_data is stable while
  // rd_valid is high and rd_ready is low.
  assign full    = (level_q == DEPTH_L);
  assign ram_cnt = level_q - LW'(rd_valid_q);
  assign wr_acc  = wr_valid && !full && !flush;
  assign consume = rd_valid_q && rd_ready;
  // Refill the output register whenever it is empty or being drained this edge.
  assign ram_re  = (ram_cnt != '0) && (!rd_valid_q || rd_ready) && !flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(wr_acc);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(ram_re);
    level_d    = level_q + LW'(wr_acc) - LW'(consume);
    rd_valid_d = rd_valid_q;
    if (ram_re) begin
      rd_valid_d = 1'b1;
    end else if (consume) begin
      rd_valid_d = 1'b0;
    end
    ovf_d = ovf_q | (wr_valid && full);
    udf_d = udf_q | (rd_ready && !rd_valid_q);
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  ram_pdp_param #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign wr_ready    = !full;
  assign rd_valid    = rd_valid_q;
  assign level       = level_q;
  assign almost_full = (level_q >= AFULL_L);
  assign empty       = (level_q == '0);
  assign ovf_err     = ovf_q;
  assign udf_err     = udf_q;

endmodule
